// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller backed by a single-port synchronous RAM.
// One RAM operation per cycle. A prefetch read always wins over a push.
// A 2-entry output buffer hides the RAM's 1-cycle read latency from the consumer.
module ram_fifo_ctrl #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_BITS-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] out_data_o,
    output logic [ADDR_BITS+1:0] count_o,
    output logic                 ram_rden_o,
    output logic                 ram_wren_o,
    output logic [ADDR_BITS-1:0] ram_addr_o,
    output logic [DATA_BITS-1:0] ram_wdata_o,
    input  logic [DATA_BITS-1:0] ram_rdata_i
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   MEM_FULL = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   mem_cnt_q, mem_cnt_d;
    logic                 rd_pend_q;
    logic [DATA_BITS-1:0] ob0_q, ob0_d;
    logic [DATA_BITS-1:0] ob1_q, ob1_d;
    logic [1:0]           ob_cnt_q, ob_cnt_d;
    // Holds IN_READY low while reset is asserted and for the first cycle after release.
    logic                 en_q;

    logic [2:0] occ;
    logic       rd_issue;
    logic       push;
    logic       pop;

    // Arbitration and handshakes, from registered state plus the push/pop inputs.
    always_comb begin
        occ         = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q};
        rd_issue    = (mem_cnt_q != '0) && (occ < 3'd2);
        in_ready_o  = en_q && !rd_issue && (mem_cnt_q != MEM_FULL);
        out_valid_o = (ob_cnt_q != 2'd0);
        out_data_o  = ob0_q;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
        ram_rden_o  = rd_issue;
        ram_wren_o  = push;
        ram_addr_o  = rd_issue ? rd_ptr_q : wr_ptr_q;
        ram_wdata_o = in_data_i;
        count_o     = {1'b0, mem_cnt_q}
                    + {{(ADDR_BITS+1){1'b0}}, rd_pend_q}
                    + {{ADDR_BITS{1'b0}}, ob_cnt_q};
    end

    // Next-state for pointers, RAM occupancy and the output buffer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        ob_cnt_d  = ob_cnt_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            mem_cnt_d = mem_cnt_q + CNT_ONE;
        end else if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            mem_cnt_d = mem_cnt_q - CNT_ONE;
        end

        // Pop frees the head before the returning read word is appended.
        if (pop) begin
            ob0_d    = ob1_q;
            ob_cnt_d = ob_cnt_q - 2'd1;
        end
        if (rd_pend_q) begin
            if (ob_cnt_d == 2'd0) ob0_d = ram_rdata_i;
            else                  ob1_d = ram_rdata_i;
            ob_cnt_d = ob_cnt_d + 2'd1;
        end
    end

    // State registers; reset drops any read in flight so stale RAM data is never captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            ob0_q     <= '0;
            ob1_q     <= '0;
            ob_cnt_q  <= 2'd0;
            en_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_issue;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
            ob_cnt_q  <= ob_cnt_d;
            en_q      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a small RAM (DEPTH=8) and a queue scoreboard.
module tb_ram_fifo_ctrl;
    localparam int AB    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AB+1:0] count;
    logic          ram_rden, ram_wren;
    logic [AB-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sbq[$];
    bit chk_rdy = 1'b0;
    bit last_push = 1'b0;

    ram_fifo_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .count_o(count),
        .ram_rden_o(ram_rden), .ram_wren_o(ram_wren), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; read data appears the cycle after RDEN.
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        if (ram_rden) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From posedge+1 to the sampling point at the falling edge.
    task automatic half();
        #4;
    endtask

    // Per-cycle invariants, scoreboard update at the edge, then posedge+1.
    task automatic fin();
        bit p, q;
        chk("rd_wr_excl", int'(ram_rden & ram_wren), 0);
        chk("count", int'(count), sbq.size());
        if (chk_rdy) chk("rdy_vs_rd", int'(in_ready), int'(!ram_rden));
        p = in_valid && in_ready;
        q = out_valid && out_ready;
        if (q) begin
            if (sbq.size() == 0) chk("pop_empty", int'(out_valid), 0);
            else                 chk("data", int'(out_data), int'(sbq[0]));
        end
        @(posedge clk);
        if (q && sbq.size() != 0) void'(sbq.pop_front());
        if (p) sbq.push_back(in_data);
        last_push = p;
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic rst_chk();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_rden", int'(ram_rden), 0);
        chk("rst_wren", int'(ram_wren), 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        rst_chk();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        repeat (2) tick();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
        tick();
    endtask

    initial begin
        int i, n;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        #1;
        do_reset();

        // Test 1: single push into an empty FIFO, 3-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h1111;
        half();
        chk("t1_in_ready", int'(in_ready), 1);
        chk("t1_wren", int'(ram_wren), 1);
        chk("t1_waddr", int'(ram_addr), 0);
        chk("t1_wdata", int'(ram_wdata), 16'h1111);
        fin();
        in_valid = 1'b0;
        half();
        chk("t1_rden", int'(ram_rden), 1);
        chk("t1_raddr", int'(ram_addr), 0);
        chk("t1_ov_t1", int'(out_valid), 0);
        fin();
        half();
        chk("t1_ov_t2", int'(out_valid), 0);
        chk("t1_rden_t2", int'(ram_rden), 0);
        fin();
        half();
        chk("t1_ov_t3", int'(out_valid), 1);
        chk("t1_od_t3", int'(out_data), 16'h1111);
        fin();
        half();
        chk("t1_count_end", int'(count), 0);
        chk("t1_ov_end", int'(out_valid), 0);
        fin();

        // Test 2: fill to DEPTH+2 with no pops, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < DEPTH + 2 && n < 200) begin
            in_data = DW'(acc);
            tick();
            if (last_push) acc++;
            n++;
        end
        chk("t2_fill", acc, DEPTH + 2);
        in_data = DW'(DEPTH + 2);
        half();
        chk("t2_full_rdy", int'(in_ready), 0);
        chk("t2_full_cnt", int'(count), DEPTH + 2);
        fin();
        drain(100);

        // Test 3: sustained streaming for 3*DEPTH words, pointers wrap
        chk_rdy = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < 3 * DEPTH && n < 400) begin
            in_data = DW'(16'h0100 + acc);
            tick();
            if (last_push) acc++;
            n++;
        end
        chk("t3_stream", acc, 3 * DEPTH);
        drain(50);
        chk_rdy = 1'b0;

        // Test 4: random push traffic with ~30% consumer backpressure
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 9) >= 3);
            tick();
        end
        drain(100);

        // Test 5: async reset with a read in flight and a word buffered
        out_ready = 1'b0;
        in_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            in_data = DW'(16'h5000 + acc);
            tick();
            if (last_push) acc++;
        end
        chk("t5_accepts", acc, 2);
        in_valid = 1'b0;
        chk("t5_pre_ov", int'(out_valid), 1);
        chk("t5_pre_cnt", int'(count), 2);
        rst_n = 1'b0;
        #1;
        rst_chk();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbq.delete();
        for (int k = 0; k < 5; k++) begin
            half();
            chk("t5_idle_ov", int'(out_valid), 0);
            fin();
        end
        in_valid = 1'b1; in_data = 16'h0C0C;
        n = 0;
        last_push = 1'b0;
        while (!last_push && n < 10) begin
            tick();
            n++;
        end
        chk("t5_push_c", int'(last_push), 1);
        drain(20);

        // Test 6: push A, blocked cycle for the read, push B
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'hAAAA;
        half();
        chk("t6_a_rdy", int'(in_ready), 1);
        chk("t6_a_wren", int'(ram_wren), 1);
        chk("t6_a_addr", int'(ram_addr), 0);
        fin();
        in_data = 16'hBBBB;
        half();
        chk("t6_blk_rdy", int'(in_ready), 0);
        chk("t6_blk_rden", int'(ram_rden), 1);
        chk("t6_blk_addr", int'(ram_addr), 0);
        fin();
        half();
        chk("t6_raw_rdata", int'(ram_rdata), 16'hAAAA);
        chk("t6_b_rdy", int'(in_ready), 1);
        chk("t6_b_addr", int'(ram_addr), 1);
        fin();
        in_valid = 1'b0;
        half();
        chk("t6_ov_a", int'(out_valid), 1);
        chk("t6_od_a", int'(out_data), 16'hAAAA);
        fin();
        half();
        chk("t6_gap", int'(out_valid), 0);
        fin();
        half();
        chk("t6_ov_b", int'(out_valid), 1);
        chk("t6_od_b", int'(out_data), 16'hBBBB);
        fin();
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
